// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP
  } state_t;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_PASSB} aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_PASSB = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from op class, funct3 and funct7.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  aluop_t               aluop,
  input  logic                 rtype,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output logic [ALUCTRL_W-1:0] aluctrl,
  output logic                 legal
);

  logic [3:0] code;

  always_comb begin
    code  = ALU_ADD;
    legal = 1'b1;
    case (funct3)
      3'b000:  code = (rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    // legality only matters for R-type and immediate shifts
    if (rtype)
      legal = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    else if (funct3 == 3'b001)
      legal = (funct7 == 7'b0000000);
    else if (funct3 == 3'b101)
      legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    case (aluop)
      AOP_ADD:   code = ALU_ADD;
      AOP_SUB:   code = ALU_SUB;
      AOP_PASSB: code = ALU_PASSB;
      default:   ;
    endcase
  end

  assign aluctrl = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory handshake and sticky illegal trap.
// Define CU_FULL_BRANCH_EN to accept blt/bge/bltu/bgeu; otherwise they trap.
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC + branch/jump offset
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | load request at ALUOut
// MEMWB    | rd <= load data
// MEMWRITE | store request at ALUOut
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | rd <= ALUOut (OldPC+4 for jalr)
// BRANCH   | compare, PC <= ALUOut if taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// JALR     | PC <= rs1 + imm
// LUI      | ALUOut <= U immediate
// TRAP     | illegal instruction, parked until reset
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 Zero,
  input  logic                 LT,
  input  logic                 LTU,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic                 illegal
);

  state_t     state, state_n;
  logic       run_q;
  aluop_t     aluop;
  logic [2:0] imm_sel;
  logic       funct_legal, br_legal, rtype;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign rtype         = (opcode == OP_R);
  assign unused_fields = ^{instr[24:15], instr[11:7]};

`ifdef CU_FULL_BRANCH_EN
  assign br_legal = funct3[2] | ~funct3[1];
`else
  assign br_legal = (funct3[2:1] == 2'b00);
`endif

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .aluop  (aluop),
    .rtype  (rtype),
    .funct3 (funct3),
    .funct7 (instr[31:25]),
    .aluctrl(ALUctrl),
    .legal  (funct_legal)
  );

  // run_q holds off the first fetch until the cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    imm_sel   = IMM_I;
    aluop     = AOP_ADD;
    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_n = DECODE;
          end
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        // jal reuses this precomputed target, so it needs the J offset
        imm_sel = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_R:              state_n = funct_legal ? EXECR : TRAP;
          OP_I:              state_n = funct_legal ? EXECI : TRAP;
          OP_BRANCH:         state_n = br_legal ? BRANCH : TRAP;
          OP_JAL:            state_n = JAL;
          OP_JALR:           state_n = JALR;
          OP_LUI:            state_n = LUI;
          default:           state_n = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        imm_sel = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_n = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_n   = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_n = FETCH;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = AOP_FUNCT;
        state_n = ALUWB;
      end
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = AOP_FUNCT;
        state_n = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        // jalr's ALUOut holds the target, so the link value is formed here
        if (opcode == OP_JALR) begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
        end
        state_n = FETCH;
      end
      BRANCH: begin
        ALUSrcA = SRCA_RS1;
        imm_sel = IMM_B;
        aluop   = AOP_SUB;
        PCWrite = branch_cond(funct3, Zero, LT, LTU);
        state_n = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        imm_sel = IMM_J;
        PCWrite = 1'b1;
        state_n = ALUWB;
      end
      JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
        state_n   = ALUWB;
      end
      LUI: begin
        ALUSrcB = SRCB_IMM;
        imm_sel = IMM_U;
        aluop   = AOP_PASSB;
        state_n = ALUWB;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  assign ImmSrc  = IMMSRC_W'(imm_sel);
  assign illegal = (state == TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors.
module tb_multicycle_control_unit;

  logic        clk, rst_n;
  logic [31:0] instr;
  logic        Zero, LT, LTU, mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUctrl;
  logic [6:0]  en;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_ADDI = 32'h40000093;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_BAD  = 32'h00000000;

  // en = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_FWAIT = 7'b1000000;
  localparam logic [6:0] E_FDONE = 7'b1001100;
  localparam logic [6:0] E_RD    = 7'b1010000;
  localparam logic [6:0] E_WR    = 7'b1110000;
  localparam logic [6:0] E_PC    = 7'b0000100;
  localparam logic [6:0] E_REG   = 7'b0000010;
  localparam logic [6:0] E_TRAP  = 7'b0000001;

  assign en = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal};

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .Zero(Zero), .LT(LT), .LTU(LTU),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic rdy,
                      input logic [6:0] exp_en);
    @(negedge clk);
    instr     = ins;
    mem_ready = rdy;
    #1;
    chk(tag, 32'(en), 32'(exp_en));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1 chk("reset_en", 32'(en), 32'(E_NONE));
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1 chk("release_no_req", 32'(en), 32'(E_NONE));
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; mem_ready = 1'b0; Zero = 1'b0; LT = 1'b0; LTU = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_en", 32'(en), 32'(E_NONE));
    mem_ready = 1'b1;
    #1 chk("rst_ready_ignored", 32'(en), 32'(E_NONE));
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1 chk("first_no_req", 32'(en), 32'(E_NONE));

    // add x3,x1,x2
    step("add_fetch", I_ADD, 1'b1, E_FDONE);
    chk("fetch_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b00_10_10));
    chk("fetch_aluctrl", 32'(ALUctrl), 32'd0);
    step("add_decode", I_ADD, 1'b0, E_NONE);
    chk("decode_mux", 32'({ALUSrcA, ALUSrcB, ImmSrc}), 32'(7'b01_01_010));
    step("add_execr", I_ADD, 1'b0, E_NONE);
    chk("add_aluctrl", 32'(ALUctrl), 32'd0);
    chk("execr_mux", 32'({ALUSrcA, ALUSrcB}), 32'(4'b10_00));
    step("add_aluwb", I_ADD, 1'b0, E_REG);
    chk("aluwb_res", 32'(ResultSrc), 32'd0);

    step("sub_fetch", I_SUB, 1'b1, E_FDONE);
    step("sub_decode", I_SUB, 1'b0, E_NONE);
    step("sub_execr", I_SUB, 1'b0, E_NONE);
    chk("sub_aluctrl", 32'(ALUctrl), 32'd1);
    step("sub_aluwb", I_SUB, 1'b0, E_REG);

    // lw with three wait cycles: 8 cycles total
    step("lw_fetch", I_LW, 1'b1, E_FDONE);
    step("lw_decode", I_LW, 1'b0, E_NONE);
    step("lw_memadr", I_LW, 1'b0, E_NONE);
    chk("lw_memadr_mux", 32'({ALUSrcA, ALUSrcB, ImmSrc}), 32'(7'b10_01_000));
    for (int i = 0; i < 3; i++) step("lw_wait", I_LW, 1'b0, E_RD);
    step("lw_ready", I_LW, 1'b1, E_RD);
    step("lw_memwb", I_LW, 1'b0, E_REG);
    chk("lw_memwb_res", 32'(ResultSrc), 32'd1);

    // sw with one fetch wait
    step("sw_fetch_wait", I_SW, 1'b0, E_FWAIT);
    step("sw_fetch", I_SW, 1'b1, E_FDONE);
    step("sw_decode", I_SW, 1'b0, E_NONE);
    step("sw_memadr", I_SW, 1'b0, E_NONE);
    chk("sw_immsrc", 32'(ImmSrc), 32'd1);
    step("sw_memwrite", I_SW, 1'b1, E_WR);

    Zero = 1'b1;
    step("beq_fetch", I_BEQ, 1'b1, E_FDONE);
    step("beq_decode", I_BEQ, 1'b0, E_NONE);
    step("beq_taken", I_BEQ, 1'b0, E_PC);
    chk("beq_aluctrl", 32'(ALUctrl), 32'd1);
    step("bne_fetch", I_BNE, 1'b1, E_FDONE);
    step("bne_decode", I_BNE, 1'b0, E_NONE);
    step("bne_not_taken", I_BNE, 1'b0, E_NONE);
    Zero = 1'b0;

    step("addi_fetch", I_ADDI, 1'b1, E_FDONE);
    step("addi_decode", I_ADDI, 1'b0, E_NONE);
    step("addi_execi", I_ADDI, 1'b0, E_NONE);
    chk("addi_aluctrl", 32'(ALUctrl), 32'd0);
    step("addi_aluwb", I_ADDI, 1'b0, E_REG);

    step("srai_fetch", I_SRAI, 1'b1, E_FDONE);
    step("srai_decode", I_SRAI, 1'b0, E_NONE);
    step("srai_execi", I_SRAI, 1'b0, E_NONE);
    chk("srai_aluctrl", 32'(ALUctrl), 32'd9);
    step("srai_aluwb", I_SRAI, 1'b0, E_REG);

    step("jal_fetch", I_JAL, 1'b1, E_FDONE);
    step("jal_decode", I_JAL, 1'b0, E_NONE);
    step("jal_pc", I_JAL, 1'b0, E_PC);
    chk("jal_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b01_10_00));
    step("jal_aluwb", I_JAL, 1'b0, E_REG);

    step("jalr_fetch", I_JALR, 1'b1, E_FDONE);
    step("jalr_decode", I_JALR, 1'b0, E_NONE);
    step("jalr_pc", I_JALR, 1'b0, E_PC);
    chk("jalr_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b10_01_10));
    step("jalr_aluwb", I_JALR, 1'b0, E_REG);
    chk("jalr_link_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b01_10_10));

    step("lui_fetch", I_LUI, 1'b1, E_FDONE);
    step("lui_decode", I_LUI, 1'b0, E_NONE);
    step("lui_exec", I_LUI, 1'b0, E_NONE);
    chk("lui_ctl", 32'({ImmSrc, ALUctrl}), 32'({3'b100, 4'd6}));
    step("lui_aluwb", I_LUI, 1'b0, E_REG);

`ifdef CU_FULL_BRANCH_EN
    LT = 1'b1;
    step("blt_fetch", I_BLT, 1'b1, E_FDONE);
    step("blt_decode", I_BLT, 1'b0, E_NONE);
    step("blt_taken", I_BLT, 1'b0, E_PC);
    LT = 1'b0;
    step("blt2_fetch", I_BLT, 1'b1, E_FDONE);
    step("blt2_decode", I_BLT, 1'b0, E_NONE);
    step("blt_not_taken", I_BLT, 1'b0, E_NONE);
`else
    LT = 1'b1;
    step("blt_fetch", I_BLT, 1'b1, E_FDONE);
    step("blt_decode", I_BLT, 1'b0, E_NONE);
    step("blt_trap", I_BLT, 1'b0, E_TRAP);
    step("blt_trap_sticky", I_BLT, 1'b1, E_TRAP);
    LT = 1'b0;
`endif

    // reset in the middle of a pending store
    do_reset();
    step("rsw_fetch", I_SW, 1'b1, E_FDONE);
    step("rsw_decode", I_SW, 1'b0, E_NONE);
    step("rsw_memadr", I_SW, 1'b0, E_NONE);
    step("rsw_memwrite", I_SW, 1'b0, E_WR);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_write", 32'(en), 32'(E_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_idle", 32'(en), 32'(E_NONE));

    step("bad_fetch", I_BAD, 1'b1, E_FDONE);
    step("bad_decode", I_BAD, 1'b0, E_NONE);
    step("bad_trap", I_BAD, 1'b0, E_TRAP);
    step("bad_trap_ready", I_BAD, 1'b1, E_TRAP);
    step("bad_trap_other", I_ADD, 1'b1, E_TRAP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the shared-memory RV32I datapath, replacing the single-cycle combinational decoder. Sequences each instruction through fetch/decode/execute/memory/writeback and handshakes with a variable-latency unified memory. Adds full branch-condition and wider ALU-op decode, plus a sticky illegal-instruction trap. Sits between the instruction register and the datapath multiplexers, register file and memory port.

## Interface
- One clock; reset is asynchronous and active-low.
- ALUCTRL_W, 4: ALU control width; must be ≥4.
- IMMSRC_W, 3: immediate-select width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; only read in DECODE and later states.
- Zero, LT, LTU  in  1 each  ALU flags: equal, signed less-than, unsigned less-than of SrcA vs SrcB.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- MemWrite  out  1  write strobe; only with mem_req.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite, PCWrite, RegWrite  out  1 each  register enables.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- ImmSrc  out  IMMSRC_W  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUctrl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 slt, 6 passB, 7 xor, 8 srl, 9 sra, 10 sltu.
- illegal  out  1  sticky trap flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- FETCH: mem_req=1, AdrSrc=0, ALU computes PC+4. Hold until mem_ready; on mem_ready cycle IRWrite=1, PCWrite=1, go DECODE.
- DECODE: ALU computes OldPC+imm(B) into ALUOut. Opcode 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; else → TRAP.
- MEMADR: rs1+imm; → MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, AdrSrc=1; hold until mem_ready, then → MEMWB. MEMWB: RegWrite=1, ResultSrc=data → FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1; hold until mem_ready → FETCH.
- EXECR/EXECI: ALUctrl from funct3/funct7[5]; sub only for R-type with funct7[5]=1; srai/sra by funct7[5]. → ALUWB (RegWrite=1) → FETCH.
- BRANCH: ALU sub rs1,rs2; PCWrite = condition (beq Zero, bne !Zero, blt LT, bge !LT, bltu LTU, bgeu !LTU); ResultSrc=ALUOut → FETCH.
- JAL: PCWrite=1 from ALUOut, ALU computes OldPC+4 → ALUWB. JALR: target rs1+imm(I), PCWrite=1, → ALUWB with OldPC+4.
- LUI: ImmSrc U, ALUctrl passB → ALUWB.
- TRAP: illegal=1, all enables and mem_req 0; stays until reset.
- Unused funct3 in OP/OP-IMM → TRAP.
- Outputs are Moore-decoded from state plus instr/flags; no enable asserted outside its listed state.

## Timing
- Reset: state=FETCH, illegal=0; all enables, mem_req, MemWrite 0 while rst_n low; first request the cycle after release.
- Cycles with 0-wait memory (mem_ready same cycle): branch 3, R/I/LUI/JAL/JALR 4, store 4, load 5; each memory wait adds one.
- mem_req/AdrSrc/MemWrite stable until mem_ready; no request withdrawal.
- rst_n low mid-access: request dropped immediately (asynchronous), no write completes.

## Configuration
- CU_FULL_BRANCH_EN defined: all six branch conditions. Undefined: only beq/bne; other branch funct3 → TRAP.

## Structure
- Package ctrl_pkg: state enum, opcode constants, ALUctrl and ImmSrc codes, mux-select encodings.
- Sub-module alu_decoder: combinational funct3/funct7/op → ALUctrl.

## Test plan
- Reset then add x3,x1,x2 with 0-wait memory → FETCH,DECODE,EXECR,ALUWB; RegWrite high one cycle in cycle 4, ALUctrl=0.
- lw with mem_ready delayed 3 cycles in MEMREAD → mem_req/AdrSrc=1 held 4 cycles, RegWrite once, total 8 cycles.
- sw → MemWrite=1 only in MEMWRITE with mem_req, RegWrite never asserted.
- blt with LT=1 then LT=0 → PCWrite 1 then 0 in BRANCH; with macro undefined → illegal=1.
- sub (funct7=0100000) → ALUctrl=1; addi with instr[30]=1 → ALUctrl=0; srai → 9.
- opcode 0000000 → TRAP, illegal sticky, no enables; rst_n low mid-MEMWRITE → MemWrite drops immediately, restart at FETCH.
